// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side signal bundle for mem_port_arbiter
// slave is the arbiter's view; master is the requesters/memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_data;

  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_ack;
  logic [DATA_W-1:0] ld_data;

  logic              st_req;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic [2:0]        st_type;
  logic              st_ack;

  logic              mem_rd_req;
  logic              mem_wr_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [2:0]        mem_wtype;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              bad_type;

  modport slave (
    input  if_req, if_addr, ld_req, ld_addr,
    input  st_req, st_addr, st_data, st_type, mem_rdata,
    output if_ack, if_data, ld_ack, ld_data, st_ack,
    output mem_rd_req, mem_wr_req, mem_addr, mem_wdata, mem_wtype,
    output busy, bad_type
  );

  modport master (
    output if_req, if_addr, ld_req, ld_addr,
    output st_req, st_addr, st_data, st_type, mem_rdata,
    input  if_ack, if_data, ld_ack, ld_data, st_ack,
    input  mem_rd_req, mem_wr_req, mem_addr, mem_wdata, mem_wtype,
    input  busy, bad_type
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one data-memory port between fetch, load and store units
// Optional ARB_ROUND_ROBIN_EN replaces fixed store>load>fetch priority with a rotating pointer.
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic            clock,
  input  logic            reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {WIN_IF, WIN_LD, WIN_ST} win_t;

  localparam logic [3:0] LAT = 4'(MEM_LATENCY);

  state_t            state;
  state_t            state_next;
  win_t              winner;
  win_t              win_next;
  logic              any_req;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0] addr_next;

`ifdef ARB_ROUND_ROBIN_EN
  // 0: store first, 1: load first, 2: fetch first
  logic [1:0] rr_ptr;
`endif

  assign any_req = bus.if_req | bus.ld_req | bus.st_req;

  always_comb begin : grant_select
    win_next = WIN_IF;
`ifdef ARB_ROUND_ROBIN_EN
    case (rr_ptr)
      2'd1: begin
        if (bus.ld_req)      win_next = WIN_LD;
        else if (bus.if_req) win_next = WIN_IF;
        else if (bus.st_req) win_next = WIN_ST;
      end
      2'd2: begin
        if (bus.if_req)      win_next = WIN_IF;
        else if (bus.st_req) win_next = WIN_ST;
        else if (bus.ld_req) win_next = WIN_LD;
      end
      default: begin
        if (bus.st_req)      win_next = WIN_ST;
        else if (bus.ld_req) win_next = WIN_LD;
        else                 win_next = WIN_IF;
      end
    endcase
`else
    if (bus.st_req)      win_next = WIN_ST;
    else if (bus.ld_req) win_next = WIN_LD;
    else                 win_next = WIN_IF;
`endif
  end

  always_comb begin : addr_select
    case (win_next)
      WIN_ST:  addr_next = bus.st_addr;
      WIN_LD:  addr_next = bus.ld_addr;
      default: addr_next = bus.if_addr;
    endcase
  end

  always_comb begin : next_state
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (cnt <= 4'd1) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the current state, so each strobe/ack appears
  // in the cycle after the edge that leaves the corresponding state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      winner         <= WIN_IF;
      cnt            <= 4'd0;
      rdata_q        <= '0;
      bus.if_ack     <= 1'b0;
      bus.if_data    <= '0;
      bus.ld_ack     <= 1'b0;
      bus.ld_data    <= '0;
      bus.st_ack     <= 1'b0;
      bus.mem_rd_req <= 1'b0;
      bus.mem_wr_req <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.mem_wtype  <= 3'd0;
      bus.busy       <= 1'b0;
      bus.bad_type   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr         <= 2'd0;
`endif
    end else begin
      state          <= state_next;
      bus.busy       <= (state_next != IDLE);
      bus.mem_rd_req <= 1'b0;
      bus.mem_wr_req <= 1'b0;
      bus.bad_type   <= 1'b0;
      bus.if_ack     <= 1'b0;
      bus.ld_ack     <= 1'b0;
      bus.st_ack     <= 1'b0;

      case (state)
        IDLE: begin
          if (any_req) begin
            winner       <= win_next;
            bus.mem_addr <= addr_next;
            if (win_next == WIN_ST) begin
              bus.mem_wdata <= bus.st_data;
              bus.mem_wtype <= bus.st_type;
            end
`ifdef ARB_ROUND_ROBIN_EN
            case (win_next)
              WIN_ST:  rr_ptr <= 2'd1;
              WIN_LD:  rr_ptr <= 2'd2;
              default: rr_ptr <= 2'd0;
            endcase
`endif
          end
        end
        ISSUE: begin
          cnt <= LAT;
          if (winner == WIN_ST) begin
            // Illegal store widths are dropped but still acknowledged.
            if (bus.mem_wtype > 3'd2) bus.bad_type   <= 1'b1;
            else                      bus.mem_wr_req <= 1'b1;
          end else begin
            bus.mem_rd_req <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt > 4'd1) begin
            cnt <= cnt - 4'd1;
          end else begin
            cnt <= 4'd0;
            if (winner != WIN_ST) rdata_q <= bus.mem_rdata;
          end
        end
        RESP: begin
          case (winner)
            WIN_IF: begin
              bus.if_ack  <= 1'b1;
              bus.if_data <= rdata_q;
            end
            WIN_LD: begin
              bus.ld_ack  <= 1'b1;
              bus.ld_data <= rdata_q;
            end
            default: bus.st_ack <= 1'b1;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  typedef struct {
    logic [2:0]  who;      // one-hot {st, ld, if}
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  wtype;
    logic [31:0] exp_data;
    int          exp_rd;
    int          exp_wr;
    int          exp_bad;
  } vec_t;

  typedef struct {
    logic [2:0]  who;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   ack_cnt = 0;
  int   rd_cnt  = 0;
  int   wr_cnt  = 0;
  int   bad_cnt = 0;
  int   strobe_cyc = -1;
  int   bad_cyc    = -1;
  logic [31:0] strobe_addr;
  logic [31:0] strobe_wdata;
  logic [2:0]  strobe_wtype;
  logic        hold_all = 1'b0;
  exp_t        sb[$];
  vec_t        vecs[10];
  bit [32:0]   mem [4096];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  mem_port_arbiter_if u_if ();
  mem_port_arbiter_if u_if1 ();

  mem_port_arbiter #(.MEM_LATENCY(LAT), .ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset(rst), .bus(u_if)
  );
  mem_port_arbiter #(.MEM_LATENCY(1), .ADDR_W(32), .DATA_W(32)) dut1 (
    .clock(clock), .reset(rst), .bus(u_if1)
  );

  // Word memory; unwritten words read back as addr ^ 0x5A5A0000.
  always @(posedge clock)
    if (u_if.mem_wr_req) mem[u_if.mem_addr[13:2]] <= {1'b1, u_if.mem_wdata};
  always @(negedge clock)
    u_if.mem_rdata <= mem[u_if.mem_addr[13:2]][32] ? mem[u_if.mem_addr[13:2]][31:0]
                                                   : (u_if.mem_addr ^ 32'h5A5A_0000);

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // One cycle: sample outputs just after the falling edge, score acks, drop acked reqs.
  task automatic poll();
    logic [2:0]  got;
    logic [31:0] gd;
    exp_t        e;
    @(negedge clock);
    #1;
    if (!rst) begin
      if (u_if.mem_rd_req) begin
        rd_cnt++;
        strobe_cyc  = cyc;
        strobe_addr = u_if.mem_addr;
      end
      if (u_if.mem_wr_req) begin
        wr_cnt++;
        strobe_cyc   = cyc;
        strobe_addr  = u_if.mem_addr;
        strobe_wdata = u_if.mem_wdata;
        strobe_wtype = u_if.mem_wtype;
      end
      if (u_if.bad_type) begin
        bad_cnt++;
        bad_cyc = cyc;
      end
      got = {u_if.st_ack, u_if.ld_ack, u_if.if_ack};
      if (got != 3'b000) begin
        ack_cnt++;
        gd = u_if.if_ack ? u_if.if_data : u_if.ld_data;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_ack: got acks=%b at cycle %0d, required none", got, cyc);
        end else begin
          e = sb.pop_front();
          if (!(got == e.who && cyc == e.cyc && (e.who == 3'b100 || gd == e.data))) begin
            bad++;
            $display("FAIL ack: got who=%b cyc=%0d data=0x%0h, required who=%b cyc=%0d data=0x%0h",
                     got, cyc, gd, e.who, e.cyc, e.data);
          end
        end
        if (!hold_all) begin
          if (u_if.if_ack) u_if.if_req = 1'b0;
          if (u_if.ld_ack) u_if.ld_req = 1'b0;
          if (u_if.st_ack) u_if.st_req = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_acks(input int target, input int budget);
    int n = 0;
    while (ack_cnt < target && n < budget) begin
      poll();
      n++;
    end
    check("acks_arrived", ack_cnt, target);
  endtask

  task automatic drive(input logic [2:0] who, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] wtype);
    case (who)
      3'b001: begin u_if.if_req = 1'b1; u_if.if_addr = addr; end
      3'b010: begin u_if.ld_req = 1'b1; u_if.ld_addr = addr; end
      default: begin
        u_if.st_req = 1'b1; u_if.st_addr = addr;
        u_if.st_data = wdata; u_if.st_type = wtype;
      end
    endcase
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int c, r0, w0, b0, a0;
    poll();
    c = cyc; r0 = rd_cnt; w0 = wr_cnt; b0 = bad_cnt; a0 = ack_cnt;
    drive(v.who, v.addr, v.wdata, v.wtype);
    sb.push_back('{v.who, v.exp_data, c + 3 + LAT});
    wait_acks(a0 + 1, 20);
    check($sformatf("v%0d rd_strobes", idx), rd_cnt - r0, v.exp_rd);
    check($sformatf("v%0d wr_strobes", idx), wr_cnt - w0, v.exp_wr);
    check($sformatf("v%0d bad_type", idx), bad_cnt - b0, v.exp_bad);
    if (v.exp_rd + v.exp_wr != 0) begin
      check($sformatf("v%0d strobe_addr", idx), strobe_addr, v.addr);
      check($sformatf("v%0d strobe_cyc", idx), strobe_cyc, c + 2);
    end
    if (v.exp_wr != 0) begin
      check($sformatf("v%0d wdata", idx), strobe_wdata, v.wdata);
      check($sformatf("v%0d wtype", idx), strobe_wtype, v.wtype);
    end
    if (v.exp_bad != 0) check($sformatf("v%0d bad_cyc", idx), bad_cyc, c + 2);
  endtask

  initial begin
    int c, a0, n1, ack1_n, ack1_cyc, rd1_cyc;
    logic [31:0] ack1_data;

    vecs[0] = '{3'b100, 32'h10,   32'hDEADBEEF, 3'd2, 32'h0,          0, 1, 0};
    vecs[1] = '{3'b001, 32'h10,   32'h0,        3'd0, 32'hDEADBEEF,   1, 0, 0};
    vecs[2] = '{3'b100, 32'h1000, 32'h12345678, 3'd2, 32'h0,          0, 1, 0};
    vecs[3] = '{3'b010, 32'h1000, 32'h0,        3'd0, 32'h12345678,   1, 0, 0};
    vecs[4] = '{3'b100, 32'h20,   32'h000000AB, 3'd0, 32'h0,          0, 1, 0};
    vecs[5] = '{3'b010, 32'h20,   32'h0,        3'd0, 32'h000000AB,   1, 0, 0};
    vecs[6] = '{3'b100, 32'h30,   32'h0000CAFE, 3'd5, 32'h0,          0, 0, 1};
    vecs[7] = '{3'b010, 32'h30,   32'h0,        3'd0, 32'h5A5A0030,   1, 0, 0};
    vecs[8] = '{3'b001, 32'h44,   32'h0,        3'd0, 32'h5A5A0044,   1, 0, 0};
    vecs[9] = '{3'b100, 32'h50,   32'h0000BEEF, 3'd1, 32'h0,          0, 1, 0};

    u_if.if_req = 0; u_if.if_addr = 0; u_if.ld_req = 0; u_if.ld_addr = 0;
    u_if.st_req = 0; u_if.st_addr = 0; u_if.st_data = 0; u_if.st_type = 0;
    u_if1.if_req = 0; u_if1.if_addr = 0; u_if1.ld_req = 0; u_if1.ld_addr = 0;
    u_if1.st_req = 0; u_if1.st_addr = 0; u_if1.st_data = 0; u_if1.st_type = 0;
    u_if1.mem_rdata = 0;

    repeat (3) @(negedge clock);
    #1;
    check("reset_ctrl", {u_if.mem_rd_req, u_if.mem_wr_req, u_if.busy, u_if.bad_type,
                         u_if.if_ack, u_if.ld_ack, u_if.st_ack}, 0);
    check("reset_addr", u_if.mem_addr, 0);
    check("reset_data", {u_if.if_data, u_if.ld_data}, 0);
    check("reset_ctrl_l1", {u_if1.mem_rd_req, u_if1.busy, u_if1.if_ack}, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Reset while a load sits in WAIT: everything drops at once and no ack follows.
    poll();
    c = cyc; a0 = ack_cnt;
    drive(3'b010, 32'h1000, 32'h0, 3'd0);
    repeat (3) poll();
    check("busy_in_wait", u_if.busy, 1);
    rst = 1'b1;
    u_if.ld_req = 1'b0;
    #1;
    check("rst_async_ctrl", {u_if.mem_rd_req, u_if.busy, u_if.ld_ack}, 0);
    repeat (2) poll();
    rst = 1'b0;
    repeat (10) poll();
    check("no_ack_after_rst", ack_cnt, a0);

    run_vec(vecs[1], 10);

    // Simultaneous requests at one edge.
    poll();
    c = cyc; a0 = ack_cnt;
    drive(3'b001, 32'h10,   32'h0,        3'd0);
    drive(3'b010, 32'h1000, 32'h0,        3'd0);
    drive(3'b100, 32'h2000, 32'h00000077, 3'd2);
`ifdef ARB_ROUND_ROBIN_EN
    hold_all = 1'b1;
    sb.push_back('{3'b100, 32'h0,        c + 3 + LAT});
    sb.push_back('{3'b010, 32'h12345678, c + 3 + LAT + (3 + LAT)});
    sb.push_back('{3'b001, 32'hDEADBEEF, c + 3 + LAT + 2 * (3 + LAT)});
    sb.push_back('{3'b100, 32'h0,        c + 3 + LAT + 3 * (3 + LAT)});
    wait_acks(a0 + 4, 60);
    u_if.if_req = 0; u_if.ld_req = 0; u_if.st_req = 0;
    hold_all = 1'b0;
`else
    sb.push_back('{3'b100, 32'h0,        c + 3 + LAT});
    sb.push_back('{3'b010, 32'h12345678, c + 3 + LAT + (3 + LAT)});
    sb.push_back('{3'b001, 32'hDEADBEEF, c + 3 + LAT + 2 * (3 + LAT)});
    wait_acks(a0 + 3, 40);
`endif
    repeat (8) poll();

    // MEM_LATENCY=1 instance: mem_rdata is valid only around the single WAIT edge.
    @(negedge clock);
    #1;
    c = cyc; ack1_n = 0; ack1_cyc = -1; rd1_cyc = -1; ack1_data = 0;
    u_if1.if_req = 1'b1; u_if1.if_addr = 32'h80; u_if1.mem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      #1;
      n1 = cyc - c;
      u_if1.mem_rdata = (n1 == 2) ? 32'h0BADF00D : 32'hFFFF_FFFF;
      if (u_if1.mem_rd_req) rd1_cyc = cyc;
      if (u_if1.if_ack) begin
        ack1_n++;
        ack1_cyc  = cyc;
        ack1_data = u_if1.if_data;
        u_if1.if_req = 1'b0;
      end
    end
    check("l1_ack_count", ack1_n, 1);
    check("l1_ack_cyc", ack1_cyc, c + 4);
    check("l1_data", ack1_data, 32'h0BADF00D);
    check("l1_strobe_cyc", rd1_cyc, c + 2);

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data-memory port between three requesters: instruction fetch, load unit and store unit.
- The memory samples its read and write strobes on the rising edge, so this block turns level req/ack handshakes into single-cycle strobes.
- It holds address, data and type stable while the memory access is in flight, waits a fixed memory latency, then returns the read data with a one-cycle ack.
- Sits between the fetch/load/store units and the data memory; only one access is outstanding at a time.

Parameters:
MEM_LATENCY, 2, cycles from strobe fall to valid mem_rdata / write complete; legal range 1..15
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
if_req  in  1  fetch request, level
if_addr  in  ADDR_W  fetch address
if_ack  out  1  one-cycle completion pulse to fetch
if_data  out  DATA_W  fetched word, valid while if_ack=1
ld_req  in  1  load request, level
ld_addr  in  ADDR_W  load address
ld_ack  out  1  one-cycle completion pulse to load unit
ld_data  out  DATA_W  loaded word, valid while ld_ack=1
st_req  in  1  store request, level
st_addr  in  ADDR_W  store address
st_data  in  DATA_W  store data
st_type  in  3  0=byte, 1=half, 2=word
st_ack  out  1  one-cycle store completion pulse
mem_rd_req  out  1  read strobe to memory
mem_wr_req  out  1  write strobe to memory
mem_addr  out  ADDR_W  latched address
mem_wdata  out  DATA_W  latched store data
mem_wtype  out  3  latched store type
mem_rdata  in  DATA_W  memory read data
busy  out  1  high whenever state != IDLE
bad_type  out  1  one-cycle pulse: store with st_type>2 dropped

Behaviour:
- All outputs are registered. On reset (asynchronous, takes effect immediately):
  - all outputs go to 0; state = IDLE;
  - an in-flight transaction is abandoned with no ack, and any strobe drops at once.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req=1 at a rising edge:
  - pick the winner by priority (store > load > fetch);
  - latch its address, data and type into mem_addr/mem_wdata/mem_wtype;
  - record the winner id and go to ISSUE.
  - Unused latched fields of a read keep their previous values.
- ISSUE: exactly one cycle.
  - Read: mem_rd_req=1.
  - Store: mem_wr_req=1.
  - Store with st_type>2: no strobe; bad_type pulses this cycle.
  - Next state is WAIT with the counter loaded to MEM_LATENCY.
- WAIT: strobes are 0. The counter decrements each cycle; the state lasts exactly MEM_LATENCY cycles.
  - On the final WAIT edge, mem_rdata is captured into the winner's data register (reads only).
- RESP: exactly one cycle. Only the winner's ack is 1, and its data output holds the captured word. Next state is IDLE.
- Data outputs hold their last value after ack; only the ack is pulsed.
- Latency: request sampled at edge k → ack high in the cycle following edge k+2+MEM_LATENCY (default: 4 cycles).
  - Minimum spacing between back-to-back grants is 3+MEM_LATENCY cycles.
- Requester rules:
  - A requester holds req and its payload stable until its ack.
  - It deasserts req in the cycle after ack unless it wants a new transaction.
  - A req still high in IDLE after RESP is treated as a new request.
- Request inputs are ignored outside IDLE.
  - A requester that drops req before its ack still receives the ack; the transaction completes.
- Simultaneous requests: exactly one grant per IDLE visit. The losers wait; their req stays asserted.
- Arithmetic: the counter is 4 bits wide and saturates at 0. No address arithmetic is done; byte lanes are the memory's job.

Optional Feature:
- ARB_ROUND_ROBIN_EN defined: a 2-bit rotating pointer replaces the fixed priority.
  - The last-granted requester becomes lowest priority.
  - Order after reset: store, load, fetch.
  - The pointer updates on the IDLE→ISSUE edge and resets to the store-first position.
- Undefined: fixed priority store > load > fetch; the pointer logic is absent.

Test Plan:
- Single fetch: if_addr=0x10, memory word 0xDEADBEEF.
  - mem_rd_req high for exactly 1 cycle with mem_addr=0x10.
  - if_ack 4 cycles after the sample edge with if_data=0xDEADBEEF; st_ack and ld_ack stay 0.
- Store word: st_addr=0x1000, st_data=0x12345678, st_type=2.
  - mem_wr_req 1-cycle pulse with mem_wdata=0x12345678, mem_wtype=2.
  - st_ack after 4 cycles; a following load of 0x1000 returns ld_data=0x12345678.
- Simultaneous if_req, ld_req and st_req asserted at the same edge, fixed priority: acks in order st, ld, if, spaced 5 cycles apart.
  - With ARB_ROUND_ROBIN_EN and all three held high continuously: grants cycle st, ld, if, st.
- Store with st_type=5: no mem_wr_req, bad_type pulses in the ISSUE cycle, and st_ack still arrives after 4 cycles.
- Reset asserted during WAIT of a load: mem_rd_req, busy and ld_ack are 0 immediately and no ack ever appears.
  - After release, a new fetch completes with normal 4-cycle latency.
- MEM_LATENCY=1 build: fetch ack arrives 3 cycles after the sample edge, and mem_rdata is sampled on the only WAIT edge.
